fifo_drain: RTL
===============

FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset; clock clk.
REQ-004 SHALL have port fifo_empty, input, 1, FIFO empty flag, valid in the same cycle.
REQ-005 SHALL have port fifo_read_en, output, 1, FIFO read request; one word is popped per asserted cycle.
REQ-006 SHALL have port fifo_read_data, input, WIDTH, FIFO read data, valid exactly 1 cycle after fifo_read_en.
REQ-007 SHALL have port flush, input, 1, pulse; discards all buffered and queued data.
REQ-008 SHALL have port m_valid, output, 1, output word available.
REQ-009 SHALL have port m_ready, input, 1, consumer accepts the word.
REQ-010 SHALL have port m_data, output, WIDTH, output word.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL hold a 2-entry output buffer (occ 0..2) and track inflight (0..2) reads issued but not yet returned.
REQ-013 SHALL count a transfer when m_valid && m_ready are both high at a rising edge; m_data SHALL be the oldest buffered word.
REQ-014 SHALL assert fifo_read_en only when !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
REQ-015 SHALL never assert fifo_read_en while fifo_empty is high.
REQ-016 SHALL capture fifo_read_data into the buffer tail 1 cycle after each fifo_read_en; this gives 2-cycle latency from a non-empty FIFO to m_valid.
REQ-017 SHALL sustain 1 word/cycle when m_ready is held high and the FIFO stays non-empty.
REQ-018 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-019 SHALL preserve FIFO order. No word is dropped or duplicated except under flush.
REQ-020 SHALL handle simultaneous capture and pop in one cycle; occ is unchanged and order is preserved.
REQ-021 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-022 SHALL go IDLE->STREAM when fifo_empty is low.
REQ-023 SHALL go STREAM->IDLE when occ==0 && inflight==0 && fifo_empty.
REQ-024 SHALL go from any state to FLUSH on flush=1. In the same edge, occ SHALL be set to 0 and inflight SHALL NOT be cleared.
REQ-025 In FLUSH, m_valid SHALL be 0, fifo_read_en SHALL be !fifo_empty, and returned words SHALL be discarded.
REQ-026 SHALL go FLUSH->IDLE when fifo_empty && inflight==0 (pending reads after the flush edge are counted).
REQ-027 SHALL keep flush asserted during FLUSH in FLUSH, with no other effect.

Reset
REQ-028 While reset is high at a rising edge, the block SHALL set state=IDLE, occ=0, inflight=0, m_valid=0, fifo_read_en=0, busy=0, m_data=0.
REQ-029 Reset mid-STREAM or mid-FLUSH SHALL discard all buffered and in-flight data. Read data returned in the cycle after reset SHALL be ignored.
REQ-030 Reset SHALL take priority over flush.

Configuration
REQ-031 With macro FIFO_DRAIN_COUNT_EN defined, the block SHALL add output word_count, 16 bits, equal to the number of completed transfers. It SHALL wrap 0xFFFF->0, reset to 0, and not be cleared by flush.
REQ-032 Without FIFO_DRAIN_COUNT_EN, the word_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Bench SHALL cover: FIFO holds 0x11,0x22,0x33 and m_ready=1 -> fifo_read_en high 3 consecutive cycles; m_data 0x11,0x22,0x33 on 3 consecutive cycles, the first 2 cycles after fifo_empty falls.
REQ-034 Bench SHALL cover: 4 words queued, m_ready=0 for 10 cycles -> exactly 2 reads issued; m_data=first word stable; then m_ready=1 -> 4 words in order, no gaps after the buffer drains.
REQ-035 Bench SHALL cover: random m_ready (50%) over 200 words -> output sequence equals input sequence; fifo_read_en never asserted while fifo_empty=1.
REQ-036 Bench SHALL cover: flush with occ=2, inflight=1, FIFO holding 5 words -> m_valid=0 next cycle; FIFO reaches empty; busy falls once inflight==0; no flushed word appears on m_data.
REQ-037 Bench SHALL cover: reset asserted during streaming with occ=2 -> next cycle m_valid=0, busy=0, fifo_read_en=0; with FIFO_DRAIN_COUNT_EN, word_count=0.
REQ-038 Bench SHALL cover, with FIFO_DRAIN_COUNT_EN: word_count preset to 0xFFFE, then 3 transfers -> word_count = 0x0001.

Source files
------------

// File: rtl/fifo_drain.sv
// fifo_drain: pulls words from a FIFO with 1-cycle read latency into a 2-entry output buffer
// and presents them on a valid/ready port. Define FIFO_DRAIN_COUNT_EN to add word_count.
module fifo_drain #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_read_en,
    input  logic [WIDTH-1:0] fifo_read_data,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       inflight_q, inflight_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             pop;
    logic             capture;
    logic [2:0]       committed;

    assign m_valid   = (state_q != FLUSH) && (occ_q != 2'd0);
    assign m_data    = buf0_q;
    assign pop       = m_valid && m_ready;
    // Words returning while in FLUSH are dropped on the floor.
    assign capture   = (inflight_q != 2'd0) && (state_q != FLUSH);
    assign committed = {1'b0, occ_q} + {1'b0, inflight_q} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush && (state_q != FLUSH)) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = STREAM;
                STREAM:  if ((occ_q == 2'd0) && (inflight_q == 2'd0) && fifo_empty) state_d = IDLE;
                FLUSH:   if (fifo_empty && (inflight_q == 2'd0)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_read_en = 1'b0;
        busy         = (state_q != IDLE);
        if (!reset) begin
            if (state_q == FLUSH) begin
                fifo_read_en = !fifo_empty;
            end else begin
                fifo_read_en = !fifo_empty && (committed < 3'd2);
            end
        end
    end

    // With a fixed 1-cycle read latency, whatever is requested now is the only word in flight next.
    assign inflight_d = {1'b0, fifo_read_en};

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_d = fifo_read_data;
                    else               buf1_d = fifo_read_data;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_d = fifo_read_data;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = fifo_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 2'd0;
            buf0_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
        end
    end

    always_ff @(posedge clk) begin
        buf1_q <= buf1_d;
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0] word_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q <= 16'd0;
        end else if (pop) begin
            word_count_q <= word_count_q + 16'd1;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule
